// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// frame constants and the checksum helper.
package riscv32_boot_pkg;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t ST_IDLE = 3'd0;
    localparam boot_state_t ST_LEN0 = 3'd1;
    localparam boot_state_t ST_LEN1 = 3'd2;
    localparam boot_state_t ST_DATA = 3'd3;
    localparam boot_state_t ST_CSUM = 3'd4;
    localparam boot_state_t ST_DONE = 3'd5;
    localparam boot_state_t ST_ERR  = 3'd6;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

    // MAGIC, LEN_LO, LEN_HI
    localparam int unsigned HDR_LEN = 3;

    // Running frame checksum: 8-bit sum of data bytes, wrapping.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake carrying the program image into the loader.
interface imem_boot_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs four little-endian stream bytes into one 32-bit word and flags the
// completed word for exactly one cycle after its fourth byte.
module boot_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    input  logic        clr,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0]  cnt_q,   cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q,  word_d;
    logic        valid_q, valid_d;

    // Next-state for byte position, partial word and completed-word pulse.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clr) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_en) begin
            // Newest byte enters at the top, so byte 0 ends up in [7:0].
            shift_d = {byte_in, shift_q[23:8]};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_d  = {byte_in, shift_q};
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Register assembler state; reset also cancels a pending word pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a framed program image into instruction memory and holds the core
// in reset until the whole image is written and its checksum verified.
module imem_boot_loader
    import riscv32_boot_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32,
    parameter logic [7:0]  MAGIC  = BOOT_MAGIC
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_boot_loader_if.slave rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_err
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    boot_state_t state_q, state_d;

    logic              rx_ready_q,  rx_ready_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q,  boot_err_d;

    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q,    len_d;
    logic [7:0]        acc_q,    acc_d;
    logic [17:0]       bcnt_q,   bcnt_d;
    logic [ADDR_W-1:0] waddr_q,  waddr_d;

    logic              accept_s;
    logic [15:0]       len_full_s;
    logic              last_byte_s;
    logic              asm_en_s;
    logic              asm_clr_s;
    logic [31:0]       asm_word_s;
    logic              asm_valid_s;

    assign accept_s    = rx.rx_valid && rx_ready_q;
    assign len_full_s  = {rx.rx_data, len_lo_q};
    // Data byte counter reaching 4*LEN-1 marks the final byte of the image.
    assign last_byte_s = (bcnt_q == ({len_q, 2'b00} - 18'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; every transition is gated by an accepted byte.
    always_comb begin
        state_d = state_q;
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx.rx_data == MAGIC) state_d = ST_LEN0;
                    else                     state_d = ST_IDLE;
                end
                ST_LEN0: state_d = ST_LEN1;
                ST_LEN1: begin
                    if ({1'b0, len_full_s} > DEPTH_L) state_d = ST_ERR;
                    else if (len_full_s == 16'd0)    state_d = ST_CSUM;
                    else                             state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (last_byte_s) state_d = ST_CSUM;
                    else             state_d = ST_DATA;
                end
                ST_CSUM: begin
                    if (rx.rx_data == acc_q) state_d = ST_DONE;
                    else                     state_d = ST_ERR;
                end
                ST_DONE: state_d = ST_DONE;
                ST_ERR: begin
                    if (rx.rx_data == MAGIC) state_d = ST_LEN0;
                    else                     state_d = ST_ERR;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Status outputs decoded from the upcoming state so they register with it.
    always_comb begin
        rx_ready_d  = 1'b1;
        cpu_rst_n_d = 1'b0;
        boot_done_d = 1'b0;
        boot_err_d  = 1'b0;
        case (state_d)
            ST_DONE: begin
                rx_ready_d  = 1'b0;
                cpu_rst_n_d = 1'b1;
                boot_done_d = 1'b1;
            end
            ST_ERR: begin
                boot_err_d = 1'b1;
            end
            default: begin
                rx_ready_d = 1'b1;
            end
        endcase
    end

    // Datapath next-state: length capture, checksum, byte count, write address.
    always_comb begin
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        acc_d     = acc_q;
        bcnt_d    = bcnt_q;
        waddr_d   = waddr_q;
        asm_en_s  = 1'b0;
        asm_clr_s = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_LEN0: len_lo_d = rx.rx_data;
                ST_LEN1: begin
                    len_d     = len_full_s;
                    acc_d     = 8'd0;
                    bcnt_d    = 18'd0;
                    asm_clr_s = 1'b1;
                end
                ST_DATA: begin
                    acc_d    = csum_add(acc_q, rx.rx_data);
                    bcnt_d   = bcnt_q + 18'd1;
                    asm_en_s = 1'b1;
                    // Address is latched alongside the completed word so the
                    // write strobe, address and data appear in the same cycle.
                    if (bcnt_q[1:0] == 2'd3) waddr_d = ADDR_W'({bcnt_q[17:2], 2'b00});
                    else                     waddr_d = waddr_q;
                end
                default: begin
                    asm_en_s = 1'b0;
                end
            endcase
        end else begin
            asm_en_s = 1'b0;
        end
    end

    // Register outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            acc_q       <= 8'd0;
            bcnt_q      <= 18'd0;
            waddr_q     <= '0;
        end else begin
            rx_ready_q  <= rx_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            bcnt_q      <= bcnt_d;
            waddr_q     <= waddr_d;
        end
    end

    boot_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_en    (asm_en_s),
        .byte_in    (rx.rx_data),
        .clr        (asm_clr_s),
        .word_out   (asm_word_s),
        .word_valid (asm_valid_s)
    );

    assign rx.rx_ready = rx_ready_q;
    assign imem_we     = asm_valid_s;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = asm_word_s;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign boot_done   = boot_done_q;
    assign boot_err    = boot_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected imem writes,
// a negedge monitor pops and compares every write strobe.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        boot_done;
    logic        boot_err;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [63:0] mon_e;
    logic        prev_cpu = 1'b0;
    bit          stall_mode = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader_if rx();

    imem_boot_loader #(.DEPTH(256), .ADDR_W(32), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each write strobe against the scoreboard, and make sure
    // the core is only released once all expected writes have been seen.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_waddr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", imem_waddr, mon_e[63:32]);
                check("write_data", imem_wdata, mon_e[31:0]);
            end
        end
        if (cpu_rst_n && !prev_cpu) check("cpu_rst_after_writes", exp_q.size(), 32'd0);
        prev_cpu = cpu_rst_n;
    end

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        int g;
        if (stall_mode) begin
            g = $urandom_range(0, 2);
            repeat (g) @(negedge clk);
        end
        @(negedge clk);
        rx.rx_valid = 1'b1;
        rx.rx_data  = b;
        n = 0;
        while (!rx.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx.rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: rx_ready stayed 0 for byte 0x%0h", b);
            rx.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 rx.rx_valid = 1'b0;
        end
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) send(tx_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        rx.rx_valid = 1'b0;
        @(negedge clk);
        check("rst_rx_ready",  rx.rx_ready, 32'd0);
        check("rst_imem_we",   imem_we,     32'd0);
        check("rst_waddr",     imem_waddr,  32'd0);
        check("rst_wdata",     imem_wdata,  32'd0);
        check("rst_cpu_rst_n", cpu_rst_n,   32'd0);
        check("rst_boot_done", boot_done,   32'd0);
        check("rst_boot_err",  boot_err,    32'd0);
        rst_n = 1'b1;
    endtask

    task automatic check_status(input string tag, input logic done, input logic crst,
                                input logic err, input logic rdy);
        @(negedge clk);
        check({tag, "_boot_done"}, boot_done,   {31'd0, done});
        check({tag, "_cpu_rst_n"}, cpu_rst_n,   {31'd0, crst});
        check({tag, "_boot_err"},  boot_err,    {31'd0, err});
        check({tag, "_rx_ready"},  rx.rx_ready, {31'd0, rdy});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;

        // Good 2-word frame. Data bytes sum to 0xE0.
        do_reset();
        expect_write(32'h0, 32'h00100513);
        expect_write(32'h4, 32'h00200593);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
        send_all();
        check_status("good2", 1'b1, 1'b1, 1'b0, 1'b0);

        // Bad checksum, then recovery with a good frame.
        do_reset();
        expect_write(32'h0, 32'h00100513);
        expect_write(32'h4, 32'h00200593);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hDF};
        send_all();
        check_status("badcsum", 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hA5);
        check_status("resync_magic", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_write(32'h0, 32'h00100513);
        expect_write(32'h4, 32'h00200593);
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
        send_all();
        check_status("recover", 1'b1, 1'b1, 1'b0, 1'b0);

        // Garbage before MAGIC, then a 1-word frame.
        do_reset();
        expect_write(32'h0, 32'h00100513);
        tx_q = '{8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
        send_all();
        check_status("garbage", 1'b1, 1'b1, 1'b0, 1'b0);

        // LEN = 0x0101 exceeds DEPTH: error right after LEN_HI, no writes.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h01};
        send_all();
        check_status("len_big", 1'b0, 1'b0, 1'b1, 1'b1);

        // LEN = 0 with checksum 0: done with no writes.
        do_reset();
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_all();
        check_status("len_zero", 1'b1, 1'b1, 1'b0, 1'b0);

        // 4-word frame with random stalls; last word contains MAGIC as data.
        // Sum: 0x28 + 0xB8 + 0xEE + 0xA5 = 0x273 -> 0x73.
        do_reset();
        stall_mode = 1'b1;
        expect_write(32'h0, 32'h00100513);
        expect_write(32'h4, 32'h00200593);
        expect_write(32'h8, 32'h00B50633);
        expect_write(32'hC, 32'h000000A5);
        tx_q = '{8'hA5, 8'h04, 8'h00,
                 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                 8'h33, 8'h06, 8'hB5, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h73};
        send_all();
        stall_mode = 1'b0;
        check_status("stall4", 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset after the 2nd byte of word 1: word 1 must never be written.
        do_reset();
        expect_write(32'h0, 32'h00100513);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
        send_all();
        do_reset();
        check_status("after_abort", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_write(32'h0, 32'h00200593);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB8};
        send_all();
        check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("leftover_writes", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
